// File: rtl/counter_pkg.sv
// Shared constants and helpers for the mode_counter family.
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mode_counter_next.sv
// Combinational next-count and bound-event logic: clamp, step, wrap or saturate.
`default_nettype none

module mode_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_cnt_in,
  input  logic             i_load,
  input  logic             i_enab,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_next,
  output logic             o_evt
);

  localparam logic [WIDTH:0] c_min   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] c_max   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] c_range = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);

  function automatic logic [WIDTH:0] clamp(input logic [WIDTH:0] v);
    if (in_range(int'(v), int'(c_min), int'(c_max))) return v;
    else if (v < c_min) return c_min;
    else return c_max;
  endfunction

  logic [WIDTH:0] w_cur;
  logic [WIDTH:0] w_step;
  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_floor;
  logic [WIDTH:0] w_next;

  // All intermediates fit in WIDTH+1 bits because s <= R and cnt <= MAX_VAL.
  assign w_cur   = clamp({1'b0, i_cnt});
  assign w_step  = {1'b0, i_step};
  assign w_s     = (w_step > c_range) ? c_range : w_step;
  assign w_sum   = w_cur + w_s;
  assign w_floor = c_min + w_s;

  always_comb begin
    w_next = w_cur;
    o_evt  = 1'b0;
    if (i_load) begin
      w_next = clamp({1'b0, i_cnt_in});
    end else if (i_enab && (w_s != '0)) begin
      if (i_dir == DIR_UP) begin
        if (w_sum > c_max) begin
          o_evt  = 1'b1;
          w_next = (SATURATE == MODE_SAT) ? c_max : (w_sum - c_max - 1'b1) + c_min;
        end else begin
          w_next = w_sum;
        end
      end else begin
        if (w_cur >= w_floor) begin
          w_next = w_cur - w_s;
        end else begin
          o_evt  = 1'b1;
          w_next = (SATURATE == MODE_SAT) ? c_min : (c_max + 1'b1) - (w_floor - w_cur);
        end
      end
    end
  end

  assign o_next = w_next[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
// Bounded up/down counter with programmable step, wrap/saturate mode and bound flags.
`default_nettype none

module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enab,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] cnt_out,
  output logic             bound_evt,
  output logic             at_max,
  output logic             at_min
);

  generate
    if (MIN_VAL >= MAX_VAL) begin : g_bad_range
      $error("mode_counter: MIN_VAL must be below MAX_VAL");
    end
  endgenerate

  logic [WIDTH-1:0] r_cnt;
  logic             r_evt;
  logic [WIDTH-1:0] w_next;
  logic             w_evt;

  mode_counter_next #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE)
  ) u_next (
    .i_cnt   (r_cnt),
    .i_cnt_in(cnt_in),
    .i_load  (load),
    .i_enab  (enab),
    .i_dir   (dir),
    .i_step  (step),
    .o_next  (w_next),
    .o_evt   (w_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= WIDTH'(MIN_VAL);
      r_evt <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_evt <= w_evt;
    end
  end

  assign cnt_out   = r_cnt;
  assign bound_evt = r_evt;
  assign at_max    = (r_cnt == WIDTH'(MAX_VAL));
  assign at_min    = (r_cnt == WIDTH'(MIN_VAL));

endmodule

`default_nettype wire

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: three configurations driven in lockstep against a scoreboard model.
`default_nettype none

module tb_mode_counter;

  localparam int N = 3;
  localparam int MN  [N] = '{0, 4, 4};
  localparam int MX  [N] = '{31, 20, 20};
  localparam int SAT [N] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] cnt_in = '0;
  logic       load = 1'b0;
  logic       enab = 1'b0;
  logic       dir = 1'b1;
  logic [4:0] step = '0;
  logic [4:0] cnt_o [N];
  logic       evt_o [N];
  logic       amax_o[N];
  logic       amin_o[N];

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(31), .SATURATE(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .load(load), .enab(enab), .dir(dir),
    .step(step), .cnt_out(cnt_o[0]), .bound_evt(evt_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));
  mode_counter #(.WIDTH(5), .MIN_VAL(4), .MAX_VAL(20), .SATURATE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .load(load), .enab(enab), .dir(dir),
    .step(step), .cnt_out(cnt_o[1]), .bound_evt(evt_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));
  mode_counter #(.WIDTH(5), .MIN_VAL(4), .MAX_VAL(20), .SATURATE(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .load(load), .enab(enab), .dir(dir),
    .step(step), .cnt_out(cnt_o[2]), .bound_evt(evt_o[2]), .at_max(amax_o[2]), .at_min(amin_o[2]));

  typedef struct {
    int dut;
    int cnt;
    bit evt;
  } exp_t;

  exp_t q[$];
  int   m_cnt[N];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int clampv(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model(input int k, input int cur, input bit ld, input int cin,
                                input bit en, input bit d, input int st,
                                output int nc, output bit ev);
    int r, s, c, t;
    nc = cur;
    ev = 1'b0;
    if (ld) begin
      nc = clampv(cin, MN[k], MX[k]);
    end else if (en && st != 0) begin
      r = MX[k] - MN[k] + 1;
      s = (st < r) ? st : r;
      c = clampv(cur, MN[k], MX[k]);
      t = d ? c + s : c - s;
      nc = t;
      if (d && t > MX[k]) begin
        ev = 1'b1;
        nc = SAT[k] ? MX[k] : MN[k] + (t - MX[k]) - 1;
      end else if (!d && t < MN[k]) begin
        ev = 1'b1;
        nc = SAT[k] ? MN[k] : MX[k] - (MN[k] - t) + 1;
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then pop and compare.
  task automatic cyc(input bit ld, input int cin, input bit en, input bit d, input int st);
    exp_t e;
    int   nc;
    bit   ev;
    @(negedge clk);
    load = ld; cnt_in = cin[4:0]; enab = en; dir = d; step = st[4:0];
    for (int k = 0; k < N; k++) begin
      model(k, m_cnt[k], ld, cin, en, d, st, nc, ev);
      m_cnt[k] = nc;
      q.push_back('{dut: k, cnt: nc, evt: ev});
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("cnt[%0d]", e.dut), int'(cnt_o[e.dut]), e.cnt);
      check($sformatf("evt[%0d]", e.dut), int'(evt_o[e.dut]), int'(e.evt));
      check($sformatf("at_max[%0d]", e.dut), int'(amax_o[e.dut]), int'(e.cnt == MX[e.dut]));
      check($sformatf("at_min[%0d]", e.dut), int'(amin_o[e.dut]), int'(e.cnt == MN[e.dut]));
      check($sformatf("range[%0d]", e.dut),
            int'(int'(cnt_o[e.dut]) >= MN[e.dut] && int'(cnt_o[e.dut]) <= MX[e.dut]), 1);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m_cnt[k] = MN[k];
    #12 rst_n = 1'b1;

    // Reset asserted mid-count clears immediately, without a clock edge
    cyc(1, 13, 0, 1, 0);
    check("pre_reset_cnt", int'(cnt_o[0]), 13);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cnt0", int'(cnt_o[0]), 0);
    check("rst_evt0", int'(evt_o[0]), 0);
    check("rst_atmin0", int'(amin_o[0]), 1);
    check("rst_cnt1", int'(cnt_o[1]), 4);
    for (int k = 0; k < N; k++) m_cnt[k] = MN[k];
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap at both ends on the full range
    cyc(1, 30, 0, 1, 0);
    cyc(0, 0, 1, 1, 3);
    check("wrap_up_cnt", int'(cnt_o[0]), 1);
    check("wrap_up_evt", int'(evt_o[0]), 1);
    cyc(0, 0, 1, 0, 2);
    check("wrap_dn_cnt", int'(cnt_o[0]), 31);
    check("wrap_dn_evt", int'(evt_o[0]), 1);
    cyc(0, 0, 0, 1, 2);
    check("evt_pulse_end", int'(evt_o[0]), 0);

    // Saturation holds at MAX with the event repeating
    cyc(1, 18, 0, 1, 0);
    cyc(0, 0, 1, 1, 5);
    check("sat_cnt", int'(cnt_o[1]), 20);
    check("sat_evt", int'(evt_o[1]), 1);
    check("sat_atmax", int'(amax_o[1]), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 5);
      check("sat_hold_cnt", int'(cnt_o[1]), 20);
      check("sat_hold_evt", int'(evt_o[1]), 1);
    end

    // Load clamping and load-over-enable priority
    cyc(1, 2, 0, 1, 0);
    check("load_lo_clamp", int'(cnt_o[1]), 4);
    cyc(1, 25, 0, 1, 0);
    check("load_hi_clamp", int'(cnt_o[1]), 20);
    cyc(1, 10, 1, 1, 7);
    check("load_prio_cnt", int'(cnt_o[1]), 10);
    check("load_prio_evt", int'(evt_o[1]), 0);

    // Step larger than the range is limited to R and returns to the start
    cyc(1, 10, 0, 1, 0);
    cyc(0, 0, 1, 1, 31);
    check("step_clip_cnt", int'(cnt_o[2]), 10);
    cyc(0, 0, 1, 1, 0);
    check("step0_cnt", int'(cnt_o[2]), 10);
    check("step0_evt", int'(evt_o[2]), 0);

    // Randomised traffic, biased toward enabled cycles and boundary steps
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 9) == 0), $urandom_range(0, 31), ($urandom_range(0, 4) != 0),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                             : $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised successor to the team's loadable up-counter. It adds up/down direction, a programmable step, a bounded range [MIN_VAL, MAX_VAL], a wrap-or-saturate mode, and boundary/event flags. It is used for the program counter, loop/address generators and timers in the VeriRISC datapath. It is a single-clock block with an asynchronous active-low reset.

Parameters:
WIDTH, 5, counter width in bits (≥2).
MIN_VAL, 0, lower bound of count range.
MAX_VAL, 2**WIDTH-1, upper bound of count range; MIN_VAL < MAX_VAL required; elaboration error otherwise.
SATURATE, 0, 0 = wrap at bounds, 1 = saturate at bounds.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous reset, active-low.
cnt_in  input  WIDTH  load value.
load  input  1  synchronous load strobe.
enab  input  1  count enable.
dir  input  1  1 = count up, 0 = count down.
step  input  WIDTH  increment magnitude per enabled cycle.
cnt_out  output  WIDTH  registered count.
bound_evt  output  1  registered one-cycle pulse: last update crossed a bound (wrapped or saturated).
at_max  output  1  combinational: cnt_out == MAX_VAL.
at_min  output  1  combinational: cnt_out == MIN_VAL.

Behaviour:
- Reset: rst_n low asynchronously forces cnt_out = MIN_VAL and bound_evt = 0, regardless of clk. Release takes effect at the next rising edge. Reset asserted mid-count discards any in-flight update.
- Priority each rising edge: load > enab > hold.
- Load: cnt_out <= cnt_in clamped to [MIN_VAL, MAX_VAL]. bound_evt <= 0. dir, step and enab are ignored that cycle.
- Enable with step == 0: hold; bound_evt <= 0.
- Effective step: s = min(step, R), where R = MAX_VAL - MIN_VAL + 1.
- Arithmetic is done in WIDTH+1 bits, with no silent overflow of the WIDTH-bit sum.
- Up, cnt + s ≤ MAX_VAL: next = cnt + s, bound_evt <= 0.
- Up, cnt + s > MAX_VAL, with e = cnt + s - MAX_VAL:
  - Wrap mode: next = MIN_VAL + e - 1.
  - Saturate mode: next = MAX_VAL.
  - bound_evt <= 1 in both modes.
- Down, cnt - s ≥ MIN_VAL (signed compare): next = cnt - s, bound_evt <= 0.
- Down, cnt - s < MIN_VAL, with e = MIN_VAL - (cnt - s):
  - Wrap mode: next = MAX_VAL - e + 1.
  - Saturate mode: next = MIN_VAL.
  - bound_evt <= 1 in both modes.
- Saturate mode at a bound, counting further outward (e.g. at MAX_VAL counting up): cnt holds and bound_evt <= 1 every such cycle.
- Hold (enab = 0, load = 0): cnt holds; bound_evt <= 0.
- Latency: one cycle from inputs to cnt_out and bound_evt. at_max/at_min follow cnt_out combinationally with no extra latency.
- If cnt_out is somehow outside the range (not reachable by design), the next enabled update clamps the value first, then applies the step.

Decomposition:
- Shared package counter_pkg holds:
  - direction constants DIR_UP = 1, DIR_DOWN = 0;
  - mode constants MODE_WRAP = 0, MODE_SAT = 1;
  - a range-check function.
- One sub-module, mode_counter_next: purely combinational next-state and event computation (clamp, step, wrap/saturate). The top module keeps only the registers and flag decode.

Test Plan:
1. WIDTH=5, defaults. Reset low mid-count at cnt=13 -> cnt_out = 0 immediately (before the next edge), bound_evt = 0, at_min = 1.
2. Wrap mode, MIN=0, MAX=31. Load 30, then up with step=3 -> cnt_out = 1 and bound_evt pulses one cycle. Then down with step=2 -> cnt_out = 31, bound_evt = 1.
3. SATURATE=1, MIN=4, MAX=20. Load 18, then up with step=5 -> cnt_out = 20, bound_evt = 1, at_max = 1. Holding enab high for 3 more cycles -> stays 20 with bound_evt = 1 each cycle.
4. MIN=4, MAX=20. Load cnt_in=2 -> cnt_out = 4. Load cnt_in=25 -> cnt_out = 20. load and enab both high with cnt_in=10 -> cnt_out = 10 (load wins), bound_evt = 0.
5. Wrap mode, MIN=4, MAX=20 (R=17). Load 10, up with step=31 -> s=17, cnt_out = 10. Up with step=0 -> hold, bound_evt = 0.
6. Randomised 1000 cycles with a reference model for both SATURATE settings -> cnt_out and bound_evt match every cycle, and cnt_out always stays in [MIN_VAL, MAX_VAL].
